// File: rtl/player_cannon_ctrl.sv
// Player cannon controller: cannon position from debounced left/right pulses and
// the single player shot (launch, flight, explosion, retire). All outputs registered.
module player_cannon_ctrl #(
    parameter int unsigned X_INIT         = 380,
    parameter int unsigned X_MIN          = 0,
    parameter int unsigned X_MAX          = 760,
    parameter int unsigned STEP           = 4,
    parameter int unsigned SHOT_X_OFS     = 16,
    parameter int unsigned SHOT_Y_START   = 552,
    parameter int unsigned SHOT_STEP      = 8,
    parameter int unsigned SHOT_TOP       = 32,
    parameter int unsigned EXPLODE_FRAMES = 4
) (
    input  logic       clk_36MHz,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       left_pulse,
    input  logic       right_pulse,
    input  logic       fire_pulse,
    input  logic       frame_tick,
    input  logic       hit,
    output logic [9:0] cannon_x,
    output logic [9:0] shot_x,
    output logic [9:0] shot_y,
    output logic       shot_active,
    output logic       shot_exploding,
    output logic       shot_fired
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StFlying  = 2'd1,
        StExplode = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [9:0] cannon_x_q, cannon_x_d;
    logic [9:0] shot_x_q, shot_x_d;
    logic [9:0] shot_y_q, shot_y_d;
    logic [7:0] cnt_q, cnt_d;
    logic       active_q, active_d;
    logic       exploding_q, exploding_d;
    logic       fired_q, fired_d;
    logic [10:0] right_sum;

    // Cannon position: 11-bit arithmetic so neither direction can wrap.
    always_comb begin
        cannon_x_d = cannon_x_q;
        right_sum  = {1'b0, cannon_x_q} + 11'(STEP);
        if (enable) begin
            if (left_pulse && !right_pulse) begin
                if ({1'b0, cannon_x_q} < 11'(X_MIN + STEP)) begin
                    cannon_x_d = 10'(X_MIN);
                end else begin
                    cannon_x_d = cannon_x_q - 10'(STEP);
                end
            end else if (right_pulse && !left_pulse) begin
                if (right_sum > 11'(X_MAX)) begin
                    cannon_x_d = 10'(X_MAX);
                end else begin
                    cannon_x_d = right_sum[9:0];
                end
            end
        end
    end

    // Shot FSM next state; status flags are derived from the next state so they stay registered.
    always_comb begin
        state_d    = state_q;
        shot_x_d   = shot_x_q;
        shot_y_d   = shot_y_q;
        cnt_d      = cnt_q;
        fired_d    = 1'b0;
        if (enable) begin
            case (state_q)
                StIdle: begin
                    // Launch uses the pre-move cannon position; a same-cycle tick is not applied.
                    if (fire_pulse) begin
                        shot_x_d = cannon_x_q + 10'(SHOT_X_OFS);
                        shot_y_d = 10'(SHOT_Y_START);
                        fired_d  = 1'b1;
                        state_d  = StFlying;
                    end
                end
                StFlying: begin
                    if (hit) begin
                        cnt_d   = 8'(EXPLODE_FRAMES);
                        state_d = StExplode;
                    end else if (frame_tick) begin
                        if (shot_y_q < 10'(SHOT_TOP + SHOT_STEP)) begin
                            state_d = StIdle;
                        end else begin
                            shot_y_d = shot_y_q - 10'(SHOT_STEP);
                        end
                    end
                end
                StExplode: begin
                    if (frame_tick) begin
                        if (cnt_q <= 8'd1) begin
                            cnt_d   = 8'd0;
                            state_d = StIdle;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
        active_d    = (state_d == StFlying);
        exploding_d = (state_d == StExplode);
    end

    // State and output registers.
    always_ff @(posedge clk_36MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cannon_x_q  <= 10'(X_INIT);
            shot_x_q    <= 10'd0;
            shot_y_q    <= 10'd0;
            cnt_q       <= 8'd0;
            active_q    <= 1'b0;
            exploding_q <= 1'b0;
            fired_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cannon_x_q  <= cannon_x_d;
            shot_x_q    <= shot_x_d;
            shot_y_q    <= shot_y_d;
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            exploding_q <= exploding_d;
            fired_q     <= fired_d;
        end
    end

    assign cannon_x       = cannon_x_q;
    assign shot_x         = shot_x_q;
    assign shot_y         = shot_y_q;
    assign shot_active    = active_q;
    assign shot_exploding = exploding_q;
    assign shot_fired     = fired_q;

endmodule

// File: tb/tb_player_cannon_ctrl.sv
// Bench for player_cannon_ctrl: directed scenarios then random pulses against a reference model.
`timescale 1ns / 1ps
module tb_player_cannon_ctrl;

    localparam int X_INIT = 380, X_MIN = 0, X_MAX = 760, STEP = 4;
    localparam int SHOT_X_OFS = 16, SHOT_Y_START = 552, SHOT_STEP = 8, SHOT_TOP = 32;
    localparam int EXPLODE_FRAMES = 4;

    logic       clk = 1'b0;
    logic       reset_n, enable, left_pulse, right_pulse, fire_pulse, frame_tick, hit;
    logic [9:0] cannon_x, shot_x, shot_y;
    logic       shot_active, shot_exploding, shot_fired;

    always #14 clk = ~clk;

    player_cannon_ctrl dut (
        .clk_36MHz     (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .left_pulse    (left_pulse),
        .right_pulse   (right_pulse),
        .fire_pulse    (fire_pulse),
        .frame_tick    (frame_tick),
        .hit           (hit),
        .cannon_x      (cannon_x),
        .shot_x        (shot_x),
        .shot_y        (shot_y),
        .shot_active   (shot_active),
        .shot_exploding(shot_exploding),
        .shot_fired    (shot_fired)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: plain integers, shot phase as a word.
    string m_phase;
    int    m_cx, m_sx, m_sy, m_frames_left;
    int    m_fired;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = "idle";
        m_cx = X_INIT;
        m_sx = 0;
        m_sy = 0;
        m_frames_left = 0;
        m_fired = 0;
    endtask

    task automatic model_step();
        int old_cx;
        m_fired = 0;
        if (!enable) return;
        old_cx = m_cx;
        if (left_pulse && !right_pulse) begin
            m_cx = (m_cx - STEP < X_MIN) ? X_MIN : m_cx - STEP;
        end else if (right_pulse && !left_pulse) begin
            m_cx = (m_cx + STEP > X_MAX) ? X_MAX : m_cx + STEP;
        end
        if (m_phase == "idle") begin
            if (fire_pulse) begin
                m_sx = old_cx + SHOT_X_OFS;
                m_sy = SHOT_Y_START;
                m_fired = 1;
                m_phase = "flying";
            end
        end else if (m_phase == "flying") begin
            if (hit) begin
                m_phase = "explode";
                m_frames_left = EXPLODE_FRAMES;
            end else if (frame_tick) begin
                if (m_sy < SHOT_TOP + SHOT_STEP) m_phase = "idle";
                else m_sy = m_sy - SHOT_STEP;
            end
        end else begin
            if (frame_tick) begin
                m_frames_left = m_frames_left - 1;
                if (m_frames_left <= 0) begin
                    m_frames_left = 0;
                    m_phase = "idle";
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".cannon_x"}, int'(cannon_x), m_cx);
        check({tag, ".shot_x"}, int'(shot_x), m_sx);
        check({tag, ".shot_y"}, int'(shot_y), m_sy);
        check({tag, ".shot_active"}, int'(shot_active), int'(m_phase == "flying"));
        check({tag, ".shot_exploding"}, int'(shot_exploding), int'(m_phase == "explode"));
        check({tag, ".shot_fired"}, int'(shot_fired), m_fired);
    endtask

    // One clock: drive pulses, clock the DUT and the model together, then compare.
    task automatic cycle(input string tag, input bit l, input bit r, input bit f,
                         input bit t, input bit h);
        left_pulse  = l;
        right_pulse = r;
        fire_pulse  = f;
        frame_tick  = t;
        hit         = h;
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
        left_pulse  = 1'b0;
        right_pulse = 1'b0;
        fire_pulse  = 1'b0;
        frame_tick  = 1'b0;
        hit         = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        enable = 1'b1;
        left_pulse = 1'b0;
        right_pulse = 1'b0;
        fire_pulse = 1'b0;
        frame_tick = 1'b0;
        hit = 1'b0;
        model_reset();
        #20;
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Motion and clamping.
        for (int i = 0; i < 3; i++) cycle("right3", 0, 1, 0, 0, 0);
        check("cx_392", int'(cannon_x), 392);
        for (int i = 0; i < 100; i++) cycle("left100", 1, 0, 0, 0, 0);
        check("cx_clamp0", int'(cannon_x), 0);
        for (int i = 0; i < 200; i++) cycle("right200", 0, 1, 0, 0, 0);
        check("cx_clamp760", int'(cannon_x), 760);
        for (int i = 0; i < 90; i++) cycle("left90", 1, 0, 0, 0, 0);
        cycle("both", 1, 1, 0, 0, 0);
        check("cx_both400", int'(cannon_x), 400);
        for (int i = 0; i < 5; i++) cycle("to380", 1, 0, 0, 0, 0);

        // Launch and full flight to a miss.
        cycle("fire", 0, 0, 1, 1, 0);
        check("launch_x", int'(shot_x), 396);
        check("launch_y", int'(shot_y), 552);
        check("launch_fired", int'(shot_fired), 1);
        cycle("post_fire", 0, 0, 0, 0, 0);
        check("fired_once", int'(shot_fired), 0);
        for (int i = 0; i < 64; i++) begin
            cycle("fly", 0, 0, 0, 1, 0);
            cycle("gap", 0, 0, 0, 0, 0);
        end
        check("y_after64", int'(shot_y), 40);
        cycle("tick65", 0, 0, 0, 1, 0);
        check("y_after65", int'(shot_y), 32);
        cycle("tick66", 0, 0, 0, 1, 0);
        check("miss_idle", int'(shot_active), 0);

        // Refire rejection, hit with coincident tick, explosion countdown.
        cycle("fire2", 0, 0, 1, 0, 0);
        for (int i = 0; i < 44; i++) cycle("fly2", 0, 0, 0, 1, 0);
        check("y_200", int'(shot_y), 200);
        cycle("refire_left", 1, 0, 1, 0, 0);
        check("refire_x", int'(shot_x), 396);
        check("refire_cx", int'(cannon_x), 376);
        cycle("hit_tick", 0, 0, 0, 1, 1);
        check("explode_y", int'(shot_y), 200);
        check("explode_on", int'(shot_exploding), 1);
        for (int i = 0; i < 3; i++) cycle("exp_tick", 0, 0, 0, 1, 0);
        check("explode_still", int'(shot_exploding), 1);
        cycle("exp_tick4", 0, 0, 0, 1, 0);
        check("explode_done", int'(shot_exploding), 0);

        // Freeze while disabled, resume from the same shot_y.
        cycle("fire3", 0, 0, 1, 0, 0);
        cycle("fly3", 0, 0, 0, 1, 0);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) cycle("frozen", 1, 0, 1, 1, 0);
        check("frozen_y", int'(shot_y), 544);
        enable = 1'b1;
        cycle("resume", 0, 0, 0, 1, 0);
        check("resume_y", int'(shot_y), 536);

        // Asynchronous reset mid-explosion.
        cycle("hit3", 0, 0, 0, 0, 1);
        cycle("exp3", 0, 0, 0, 1, 0);
        #5;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_cx", int'(cannon_x), 380);
        @(negedge clk);
        reset_n = 1'b1;

        // Random pulses.
        for (int i = 0; i < 4000; i++) begin
            enable = ($urandom_range(0, 15) != 0);
            cycle("rand", $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 29) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
